// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART types, parity modes and baud divisor helper
// Rev 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_baud_cnt_max(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// uart_baud_cnt : enable-gated modulo-CNT_MAX counter, tick on the last count
// Rev 1.0
// ============================================================================
module uart_baud_cnt #(
    parameter int CNT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [15:0] cnt;
    logic        at_max;

    assign at_max = (cnt == 16'(CNT_MAX - 1));
    assign tick   = en && at_max;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= 16'd0;
        end else if (at_max) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : async serial transmitter, 8 data bits LSB first, opt. parity
// Rev 1.0
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int uart_bps  = 9600,
    parameter int clk_freq  = 50000000,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       system_clk,
    input  logic       system_rst,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_done
);

    localparam int BAUD_CNT_MAX = calc_baud_cnt_max(clk_freq, uart_bps);

    if (BAUD_CNT_MAX < 2 || BAUD_CNT_MAX > 65535) begin : g_bad_baud
        $error("uart_tx: BAUD_CNT_MAX out of range 2..65535");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t  state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       stop_cnt, stop_cnt_n;
    logic       parity_bit, parity_n;
    logic       tx_n, ready_n, done_n;
    logic       bit_tick;

    uart_baud_cnt #(
        .CNT_MAX (BAUD_CNT_MAX)
    ) u_baud_cnt (
        .clk  (system_clk),
        .rst  (system_rst),
        .en   (state != ST_IDLE),
        .tick (bit_tick)
    );

    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            state      <= ST_IDLE;
            shift      <= 8'd0;
            bit_cnt    <= 3'd0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_cnt    <= bit_cnt_n;
            stop_cnt   <= stop_cnt_n;
            parity_bit <= parity_n;
            tx         <= tx_n;
            tx_ready   <= ready_n;
            tx_done    <= done_n;
        end
    end

    // Outputs are computed one edge ahead so tx/tx_ready/tx_done stay registered.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        parity_n   = parity_bit;
        tx_n       = tx;
        ready_n    = tx_ready;
        done_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pi_flag) begin
                    state_n   = ST_START;
                    shift_n   = pi_data;
                    parity_n  = (PARITY == PAR_ODD) ? ~(^pi_data) : (^pi_data);
                    bit_cnt_n = 3'd0;
                    tx_n      = 1'b0;
                    ready_n   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_n   = ST_DATA;
                    tx_n      = shift[0];
                    shift_n   = shift >> 1;
                    bit_cnt_n = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == 3'd7) begin
                        stop_cnt_n = 1'b0;
                        if (PARITY != PAR_NONE) begin
                            state_n = ST_PARITY;
                            tx_n    = parity_bit;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        tx_n      = shift[0];
                        shift_n   = shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_n    = ST_STOP;
                    stop_cnt_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_n = ST_IDLE;
                        ready_n = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
                ready_n = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : directed + random frames on four configurations (8N1/8E1/8O1/8N2)
// Rev 1.0
// ============================================================================
module tb_uart_tx;

    localparam int BIT_T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pd      [4];
    logic       pf      [4];
    logic       tx_l    [4];
    logic       rdy_l   [4];
    logic       done_l  [4];

    int par_cfg  [4] = '{0, 2, 1, 0};
    int stop_cfg [4] = '{1, 1, 1, 2};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(.uart_bps(10), .clk_freq(160), .PARITY(0), .STOP_BITS(1)) dut0 (
        .system_clk(clk), .system_rst(rst), .pi_data(pd[0]), .pi_flag(pf[0]),
        .tx_ready(rdy_l[0]), .tx(tx_l[0]), .tx_done(done_l[0]));
    uart_tx #(.uart_bps(10), .clk_freq(160), .PARITY(2), .STOP_BITS(1)) dut1 (
        .system_clk(clk), .system_rst(rst), .pi_data(pd[1]), .pi_flag(pf[1]),
        .tx_ready(rdy_l[1]), .tx(tx_l[1]), .tx_done(done_l[1]));
    uart_tx #(.uart_bps(10), .clk_freq(160), .PARITY(1), .STOP_BITS(1)) dut2 (
        .system_clk(clk), .system_rst(rst), .pi_data(pd[2]), .pi_flag(pf[2]),
        .tx_ready(rdy_l[2]), .tx(tx_l[2]), .tx_done(done_l[2]));
    uart_tx #(.uart_bps(10), .clk_freq(160), .PARITY(0), .STOP_BITS(2)) dut3 (
        .system_clk(clk), .system_rst(rst), .pi_data(pd[3]), .pi_flag(pf[3]),
        .tx_ready(rdy_l[3]), .tx(tx_l[3]), .tx_done(done_l[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbits_of(input int k);
        return 10 + ((par_cfg[k] != 0) ? 1 : 0) + (stop_cfg[k] - 1);
    endfunction

    // Line bits in transmit order: start, data LSB first, parity, stop(s).
    function automatic logic [11:0] frame_bits(input int k, input logic [7:0] b);
        logic [11:0] fb;
        int ones;
        fb     = '1;
        fb[0]  = 1'b0;
        fb[8:1] = b;
        ones   = $countones(b);
        if (par_cfg[k] == 2) fb[9] = (ones % 2 == 1);
        if (par_cfg[k] == 1) fb[9] = (ones % 2 == 0);
        return fb;
    endfunction

    // Called #1 after an edge with idle DUT; returns #1 after the accept edge.
    task automatic start_frame(input int k, input logic [7:0] b);
        check("ready_before_send", 32'(rdy_l[k]), 32'd1);
        pd[k] = b;
        pf[k] = 1'b1;
        @(posedge clk); #1;
        pf[k] = 1'b0;
    endtask

    // Entered #1 after the accept edge (c=0); follows the frame to completion.
    task automatic monitor(input int k, input logic [7:0] b, input bit poke,
                           input bit chain, input logic [7:0] b2);
        logic [11:0] fb;
        int nbits, len, c, dones;
        fb    = frame_bits(k, b);
        nbits = nbits_of(k);
        len   = nbits * BIT_T;
        c     = 0;
        dones = 0;
        check("start_bit_at_accept", 32'(tx_l[k]), 32'd0);
        check("busy_at_accept", 32'(rdy_l[k]), 32'd0);
        while (rdy_l[k] !== 1'b1 && c <= len + 4) begin
            @(posedge clk); #1;
            c++;
            if (poke && c == 40) begin
                pd[k] = 8'h0F;
                pf[k] = 1'b1;
            end else if (poke && c == 41) begin
                pf[k] = 1'b0;
            end
            if (c % BIT_T == BIT_T / 2 && c / BIT_T < nbits)
                check($sformatf("k%0d_b%02h_bit%0d", k, b, c / BIT_T),
                      32'(tx_l[k]), 32'(fb[c / BIT_T]));
            if (done_l[k] === 1'b1) dones++;
        end
        check($sformatf("k%0d_frame_len", k), 32'(c), 32'(len));
        check("done_on_ready_rise", 32'(done_l[k]), 32'd1);
        check("done_pulse_count", 32'(dones), 32'd1);
        if (chain) begin
            pd[k] = b2;
            pf[k] = 1'b1;
            @(posedge clk); #1;
            pf[k] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0;
        int lows, dn;
        b0 = 8'($urandom);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pd[k] = 8'h00;
            pf[k] = 1'b0;
        end
        pd[0] = b0;
        pf[0] = 1'b1;

        // Reset held three cycles with a pending request
        repeat (3) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                check("rst_tx", 32'(tx_l[k]), 32'd1);
                check("rst_ready", 32'(rdy_l[k]), 32'd1);
                check("rst_done", 32'(done_l[k]), 32'd0);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        pf[0] = 1'b0;
        check("other_stays_idle", 32'(rdy_l[1]), 32'd1);
        monitor(0, b0, 1'b0, 1'b0, 8'h00);

        // 8N1 0x55
        start_frame(0, 8'h55);
        monitor(0, 8'h55, 1'b0, 1'b0, 8'h00);

        // Even then odd parity on 0x07
        start_frame(1, 8'h07);
        monitor(1, 8'h07, 1'b0, 1'b0, 8'h00);
        start_frame(2, 8'h07);
        monitor(2, 8'h07, 1'b0, 1'b0, 8'h00);

        // Two stop bits, second request in the tx_done cycle
        start_frame(3, 8'hA3);
        monitor(3, 8'hA3, 1'b0, 1'b1, 8'h3C);
        monitor(3, 8'h3C, 1'b0, 1'b0, 8'h00);

        // Request while busy is dropped
        start_frame(0, 8'hF0);
        monitor(0, 8'hF0, 1'b1, 1'b0, 8'h00);
        lows = 0;
        dn   = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (tx_l[0] !== 1'b1 || rdy_l[0] !== 1'b1) lows++;
            if (done_l[0] !== 1'b0) dn++;
        end
        check("no_queued_frame", 32'(lows), 32'd0);
        check("no_extra_done", 32'(dn), 32'd0);

        // Reset mid-frame aborts, next frame intact
        start_frame(0, 8'h81);
        repeat (69) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_tx", 32'(tx_l[0]), 32'd1);
        check("abort_ready", 32'(rdy_l[0]), 32'd1);
        check("abort_done", 32'(done_l[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_abort_idle", 32'(tx_l[0]), 32'd1);
        start_frame(0, 8'h81);
        monitor(0, 8'h81, 1'b0, 1'b0, 8'h00);

        // Random bytes on every configuration
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 3; r++) begin
                logic [7:0] rb;
                rb = 8'($urandom);
                start_frame(k, rb);
                monitor(k, rb, 1'b0, 1'b0, 8'h00);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
